// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that fills instruction memory and gates cpu reset
//
// Purpose: packs bytes (most-significant first) into 32-bit words, writes each
// word to instruction memory at byte addresses 0, 4, 8, ... and holds the
// pipeline in reset until the requested number of words has been loaded.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte, err_o).
//
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      one-cycle pulse starting a load (honoured in IDLE and DONE)
//   len_i        words to load, sampled with start_i, clamped to MAX_WORDS
//   rx_valid_i   byte available on rx_data_i
//   rx_data_i    program byte
//   rx_ready_o   loader accepts a byte this cycle
//   wr_en_o      memory write strobe, one cycle per word
//   wr_addr_o    byte address of the word (word index << 2)
//   wr_data_o    assembled word
//   cpu_reset_o  active-high pipeline reset
//   busy_o       load in progress
//   done_o       last load completed
//   err_o        checksum failure (constant 0 without LOADER_CHECKSUM_EN)
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              wr_en_o,
  output logic [31:0]       wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_CHECK} state_t;
  localparam state_t S_LAST = S_CHECK;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
  localparam state_t S_LAST = S_DONE;
`endif

  state_t          state, state_n;
  // Only the three older bytes need holding; the fourth comes straight off rx_data_i.
  logic [23:0]     shift_q, shift_n;
  logic [1:0]      byte_cnt, byte_cnt_n;
  logic [ADDR_W:0] word_idx, word_idx_n;
  logic [ADDR_W:0] target, target_n;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] next_idx;
  logic            accept;

  logic            rx_ready_n, wr_en_n, cpu_reset_n, busy_n, done_n;
  logic [31:0]     wr_addr_n, wr_data_n;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_n, check_sum;
  logic            err_q, err_n;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign accept = rx_valid_i && rx_ready_o;

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    byte_cnt_n  = byte_cnt;
    word_idx_n  = word_idx;
    target_n    = target;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr_o;
    wr_data_n   = wr_data_o;
    len_clamped = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    next_idx    = word_idx + ONE;
`ifdef LOADER_CHECKSUM_EN
    sum_n       = sum_q;
    err_n       = err_q;
    check_sum   = sum_q + rx_data_i;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          target_n   = len_clamped;
          word_idx_n = '0;
          byte_cnt_n = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_n      = '0;
          err_n      = 1'b0;
`endif
          // A zero-length load skips reception entirely (but still takes the checksum).
          state_n    = (len_clamped == '0) ? S_LAST : S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          shift_n    = {shift_q[15:0], rx_data_i};
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_n      = check_sum;
`endif
          if (byte_cnt == 2'd3) begin
            state_n   = S_WRITE;
            wr_en_n   = 1'b1;
            wr_data_n = {shift_q, rx_data_i};
            wr_addr_n = 32'({word_idx[ADDR_W-1:0], 2'b00});
          end
        end
      end
      S_WRITE: begin
        word_idx_n = next_idx;
        state_n    = (next_idx == target) ? S_LAST : S_RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          err_n   = (check_sum != 8'd0);
          state_n = S_DONE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Registered outputs follow the state being entered, so they line up
    // with that state for its whole duration.
`ifdef LOADER_CHECKSUM_EN
    rx_ready_n  = (state_n == S_RECV) || (state_n == S_CHECK);
    busy_n      = (state_n == S_RECV) || (state_n == S_WRITE) || (state_n == S_CHECK);
    cpu_reset_n = (state_n != S_DONE) || err_n;
`else
    rx_ready_n  = (state_n == S_RECV);
    busy_n      = (state_n == S_RECV) || (state_n == S_WRITE);
    cpu_reset_n = (state_n != S_DONE);
`endif
    done_n      = (state_n == S_DONE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      shift_q     <= '0;
      byte_cnt    <= '0;
      word_idx    <= '0;
      target      <= '0;
      rx_ready_o  <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      cpu_reset_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      shift_q     <= shift_n;
      byte_cnt    <= byte_cnt_n;
      word_idx    <= word_idx_n;
      target      <= target_n;
      rx_ready_o  <= rx_ready_n;
      wr_en_o     <= wr_en_n;
      wr_addr_o   <= wr_addr_n;
      wr_data_o   <= wr_data_n;
      cpu_reset_o <= cpu_reset_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_n;
      err_q       <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  logic [8:0]  len_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          ready_bad = 0;
  int          coinc_bad = 0;
  logic        prev_done = 1'b0;
  logic        prev_cr   = 1'b1;
  logic [7:0]  tb_sum    = 8'd0;

  prog_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .cpu_reset_o (cpu_reset_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write capture and cycle-level invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en_o) begin
      wq_addr.push_back(wr_addr_o);
      wq_data.push_back(wr_data_o);
      if (done_o !== prev_done || cpu_reset_o !== prev_cr) coinc_bad++;
    end
    if ((busy_o && !wr_en_o && !rx_ready_o) || (wr_en_o && rx_ready_o)) ready_bad++;
    prev_done = done_o;
    prev_cr   = cpu_reset_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [8:0] len);
    start_i = 1'b1;
    len_i   = len;
    tb_sum  = 8'd0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit   ok;
    repeat (gap) @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      r = rx_ready_o;
      @(negedge clk);
      if (r) ok = 1;
    end
    rx_valid_i = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %02h not accepted within 64 cycles", b);
    end
    tb_sum = tb_sum + b;
  endtask

  // Ends on the falling edge at which DONE is visible.
  task automatic finish_load;
    logic [7:0] cs;
`ifdef LOADER_CHECKSUM_EN
    cs = 8'd0 - tb_sum;
    @(negedge clk);
    send_byte(cs, 0);
`else
    cs = tb_sum;
    @(negedge clk);
`endif
  endtask

  task automatic apply_reset;
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset;
    apply_reset();
    if ({rx_ready_o, wr_en_o, busy_o, done_o, err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %05b expected 00000", {rx_ready_o, wr_en_o, busy_o, done_o, err_o});
    end
    n_checks++;
    if (wr_addr_o !== 32'h0 || wr_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr %h data %h expected 0 0", wr_addr_o, wr_data_o);
    end
    n_checks++;
    if (cpu_reset_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset_o);
    end
    n_checks++;
  endtask

  task automatic test_basic;
    logic [7:0] b [0:7];
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_start(9'd2);
    if (busy_o !== 1'b1 || rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_recv_entry: busy %b ready %b expected 1 1", busy_o, rx_ready_o);
    end
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i], 0);
      if (i == 3) begin
        if (wr_en_o !== 1'b1 || wr_addr_o !== 32'h0 || wr_data_o !== 32'h12345678) begin
          n_fail++;
          $display("FAIL basic_write0: en %b addr %h data %h expected 1 0 12345678", wr_en_o, wr_addr_o, wr_data_o);
        end
        n_checks++;
      end
    end
    if (wr_en_o !== 1'b1 || wr_addr_o !== 32'h4 || wr_data_o !== 32'h9ABCDEF0) begin
      n_fail++;
      $display("FAIL basic_write1: en %b addr %h data %h expected 1 4 9abcdef0", wr_en_o, wr_addr_o, wr_data_o);
    end
    n_checks++;
    if (done_o !== 1'b0 || cpu_reset_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pre_done: done %b cpu_reset %b expected 0 1", done_o, cpu_reset_o);
    end
    n_checks++;
    finish_load();
    if (done_o !== 1'b1 || cpu_reset_o !== 1'b0 || busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done %b cpu_reset %b busy %b wr_en %b expected 1 0 0 0", done_o, cpu_reset_o, busy_o, wr_en_o);
    end
    n_checks++;
    if (wq_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d expected 2", wq_addr.size());
    end
    n_checks++;
  endtask

  task automatic test_gaps;
    logic [7:0] b [0:7];
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    wq_addr.delete();
    wq_data.delete();
    ready_bad = 0;
    do_start(9'd2);
    for (int i = 0; i < 8; i++) send_byte(b[i], 3);
    finish_load();
    repeat (3) @(negedge clk);
    if (wq_addr.size() !== 2 || wq_addr[0] !== 32'h0 || wq_data[0] !== 32'h12345678 ||
        wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h9ABCDEF0) begin
      n_fail++;
      $display("FAIL gaps_writes: count %0d w0 %h@%h w1 %h@%h expected 12345678@0 9abcdef0@4",
               wq_addr.size(), wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
    end
    n_checks++;
    if (ready_bad !== 0 || rx_ready_o !== 1'b0 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_ready: bad cycles %0d ready %b done %b expected 0 0 1", ready_bad, rx_ready_o, done_o);
    end
    n_checks++;
  endtask

  task automatic test_len_zero;
    apply_reset();
    do_start(9'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    if (done_o !== 1'b1 || cpu_reset_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done %b cpu_reset %b busy %b expected 1 0 0", done_o, cpu_reset_o, busy_o);
    end
    n_checks++;
    repeat (4) @(negedge clk);
    if (wq_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_no_write: got %0d writes expected 0", wq_addr.size());
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_load;
    apply_reset();
    do_start(9'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    #2;
    reset_i = 1'b1;
    #1;
    if (cpu_reset_o !== 1'b1 || busy_o !== 1'b0 || rx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: cpu_reset %b busy %b ready %b expected 1 0 0", cpu_reset_o, busy_o, rx_ready_o);
    end
    n_checks++;
    @(negedge clk);
    reset_i = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h66;
    repeat (10) @(negedge clk);
    rx_valid_i = 1'b0;
    if (wq_addr.size() !== 1 || wq_data[0] !== 32'h01020304) begin
      n_fail++;
      $display("FAIL midreset_writes: count %0d first %h expected 1 01020304", wq_addr.size(), wq_data[0]);
    end
    n_checks++;
    do_start(9'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    finish_load();
    if (wq_addr.size() !== 2 || wq_addr[1] !== 32'h0 || wq_data[1] !== 32'hAABBCCDD || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload: count %0d addr %h data %h done %b expected 2 0 aabbccdd 1",
               wq_addr.size(), wq_addr[1], wq_data[1], done_o);
    end
    n_checks++;
  endtask

  task automatic test_max_len;
    int bad;
    int ready_hi;
    logic [31:0] exp;
    apply_reset();
    coinc_bad = 0;
    do_start(9'd300);
    for (int k = 0; k < 1024; k++) send_byte(k[7:0], 0);
    finish_load();
    ready_hi = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h5A;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (rx_ready_o) ready_hi++;
    end
    rx_valid_i = 1'b0;
    if (wq_addr.size() !== 256) begin
      n_fail++;
      $display("FAIL max_count: got %0d writes expected 256", wq_addr.size());
    end
    n_checks++;
    if (wq_addr[255] !== 32'h3FC || wq_data[255] !== 32'hFCFDFEFF) begin
      n_fail++;
      $display("FAIL max_last: addr %h data %h expected 3fc fcfdfeff", wq_addr[255], wq_data[255]);
    end
    n_checks++;
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      exp = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      if (wq_data[w] !== exp || wq_addr[w] !== 32'(w*4)) bad++;
    end
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL max_contents: %0d words wrong expected 0 (word 64 %h@%h)", bad, wq_data[64], wq_addr[64]);
    end
    n_checks++;
    if (ready_hi !== 0 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL max_after_done: ready high %0d cycles done %b expected 0 1", ready_hi, done_o);
    end
    n_checks++;
    if (coinc_bad !== 0) begin
      n_fail++;
      $display("FAIL max_coincident: %0d writes changed done/cpu_reset expected 0", coinc_bad);
    end
    n_checks++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    apply_reset();
    do_start(9'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'hF6, 0);
    if (done_o !== 1'b1 || err_o !== 1'b0 || cpu_reset_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_pass: done %b err %b cpu_reset %b expected 1 0 0", done_o, err_o, cpu_reset_o);
    end
    n_checks++;
    do_start(9'd1);
    if (done_o !== 1'b0 || cpu_reset_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cs_restart: done %b cpu_reset %b busy %b expected 0 1 1", done_o, cpu_reset_o, busy_o);
    end
    n_checks++;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'hF5, 0);
    if (done_o !== 1'b1 || err_o !== 1'b1 || cpu_reset_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cs_fail: done %b err %b cpu_reset %b expected 1 1 1", done_o, err_o, cpu_reset_o);
    end
    n_checks++;
    do_start(9'd0);
    if (err_o !== 1'b0 || rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cs_err_clear: err %b ready %b expected 0 1", err_o, rx_ready_o);
    end
    n_checks++;
    send_byte(8'h00, 0);
    if (done_o !== 1'b1 || err_o !== 1'b0 || cpu_reset_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_zero_len: done %b err %b cpu_reset %b expected 1 0 0", done_o, err_o, cpu_reset_o);
    end
    n_checks++;
  endtask
`endif

  initial begin
    reset_i    = 1'b1;
    start_i    = 1'b0;
    len_i      = '0;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_len_zero();
    test_reset_mid_load();
    test_max_len();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the DLX system. Receives a program as a byte stream (valid/ready) and packs bytes big-endian into 32-bit words.
- Writes each word into instruction memory at consecutive byte addresses 0, 4, 8, ...
- Holds the pipeline in reset through its own reset output until the load completes, then releases it.

Parameters:
- ADDR_W, 8, word-index width; memory depth is 2**ADDR_W words.
- MAX_WORDS, 256, upper bound on words loaded; must be <= 2**ADDR_W.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a load; honoured in IDLE and DONE only.
- len_i  in  ADDR_W+1  number of words to load; sampled with start_i.
- rx_valid_i  in  1  byte available on rx_data_i.
- rx_data_i  in  8  program byte, most-significant byte of each word first.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- wr_en_o  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr_o  out  32  byte address; always word index << 2.
- wr_data_o  out  32  assembled word.
- cpu_reset_o  out  1  active-high reset to the pipeline.
- busy_o  out  1  a load is in progress.
- done_o  out  1  last load completed.
- err_o  out  1  checksum failure (optional feature only).

Behaviour:
- Reset values: state IDLE; rx_ready_o 0; wr_en_o 0; wr_addr_o 0; wr_data_o 0; cpu_reset_o 1; busy_o 0; done_o 0; err_o 0; word and byte counters 0. All outputs are registered.
- States: IDLE, RECV, WRITE, DONE, plus CHECK when the optional feature is compiled in.
- IDLE:
  - cpu_reset_o = 1.
  - On start_i: latch min(len_i, MAX_WORDS) as target length.
  - If target length == 0, go to DONE next cycle with no write.
  - Otherwise go to RECV.
- RECV:
  - rx_ready_o = 1 and busy_o = 1.
  - A byte transfers on a clock edge where rx_valid_i && rx_ready_o.
  - Each byte shifts into the word buffer: buf <= {buf[23:0], rx_data_i}.
  - The byte counter counts 0..3 and wraps to 0.
  - Gaps in rx_valid_i are allowed; the state is held with no timeout.
  - When the 4th byte is accepted, go to WRITE. rx_ready_o drops the following cycle.
- WRITE (exactly one cycle):
  - wr_en_o = 1; wr_data_o = buf; wr_addr_o = {word_idx, 2'b00} zero-extended to 32 bits.
  - Latency: the write strobe occurs 1 cycle after the 4th byte's transfer edge.
  - Next, word_idx increments. If the new word_idx == target length, go to DONE (or CHECK); otherwise go to RECV.
- DONE:
  - done_o = 1, busy_o = 0, cpu_reset_o = 0, rx_ready_o = 0.
  - start_i restarts a load: done_o clears, cpu_reset_o reasserts, word_idx returns to 0, and the state moves to IDLE-equivalent handling (same length rules as IDLE).
- start_i during RECV or WRITE is ignored.
- word_idx never exceeds MAX_WORDS - 1 at a write; wr_addr_o cannot wrap.
- Asynchronous reset mid-load: the partial word is discarded and no further writes occur. cpu_reset_o = 1 immediately. Words already written stay in memory.
- done_o and cpu_reset_o never change within the same cycle as wr_en_o.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum covers every accepted data byte; it is cleared on start_i.
  - After the last WRITE, the state moves to CHECK: rx_ready_o = 1 and one more byte is accepted.
  - If (sum + byte) mod 256 == 0, the result is a pass: DONE with err_o = 0.
  - Otherwise DONE with err_o = 1, done_o = 1, and cpu_reset_o held at 1.
  - err_o clears on start_i or reset.
  - A zero-length load also expects the checksum byte; 0x00 passes.
- When undefined: no CHECK state and err_o is tied to 0.

Test Plan:
- Reset, start_i with len_i = 2, bytes 12 34 56 78 9A BC DE F0 with continuous valid -> write (addr 0x0, 0x12345678), then (addr 0x4, 0x9ABCDEF0); done_o = 1 and cpu_reset_o = 0 one cycle after the last write.
- Same stream with rx_valid_i low 3 cycles between every byte -> identical writes; rx_ready_o = 0 only in WRITE and DONE.
- start_i with len_i = 0 -> DONE next cycle, wr_en_o never asserted, cpu_reset_o falls.
- Pulse reset_i after 5 bytes accepted -> no write of the second word, cpu_reset_o = 1 asynchronously; a new load with len_i = 1 writes addr 0x0.
- len_i = 300 with 1200 bytes offered -> exactly 256 writes, last at addr 0x3FC; rx_ready_o stays 0 after DONE.
- LOADER_CHECKSUM_EN, len_i = 1, bytes 01 02 03 04 then checksum F6 -> err_o = 0 and cpu_reset_o = 0; checksum F5 instead -> err_o = 1 and cpu_reset_o = 1.
